// File: rtl/mutate_unit_pkg.sv
// Shared GA definitions: mutate FSM encoding, LFSR taps, default population geometry
// and generation-controller constants.
package mutate_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mut_state_t;

    localparam logic [15:0] LFSR_TAPS   = 16'hB400;
    localparam logic [15:0] GA_SEED     = 16'hACE1;
    localparam logic [8:0]  GA_MUT_RATE = 9'd32;

    localparam int GA_NUM_IND = 75;
    localparam int GA_IND_W   = 100;
    localparam int GA_POP_W   = 7501;

    // Generation controller limits
    localparam int GA_MAX_GEN  = 500;
    localparam int GA_NUM_ELITE = 2;

    function automatic logic [15:0] lfsr16_next(input logic [15:0] v);
        return {1'b0, v[15:1]} ^ (v[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/mutate_unit_if.sv
// Request/population bus between the generation controller and the mutate unit.
interface mutate_unit_if
    import mutate_unit_pkg::*;
#(
    parameter int POP_W = GA_POP_W
);
    logic             mut_start;
    logic [POP_W-1:0] sel_pop;
    logic [POP_W-1:0] mut_pop;
    logic             mut_done;

    modport master (
        output mut_start,
        output sel_pop,
        input  mut_pop,
        input  mut_done
    );

    modport slave (
        input  mut_start,
        input  sel_pop,
        output mut_pop,
        output mut_done
    );
endinterface

// File: rtl/ga_lfsr16.sv
// 16-bit right-shifting Galois LFSR, advanced only when enabled; reset loads the seed.
module ga_lfsr16
    import mutate_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [15:0] seed,
    output logic [15:0] value
);

    logic [15:0] r_lfsr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= seed;
        end else if (en) begin
            r_lfsr <= lfsr16_next(r_lfsr);
        end
    end

    assign value = r_lfsr;

endmodule

// File: rtl/mutate_unit.sv
// Mutation stage: walks the population one individual per cycle, flipping at most
// one bit per individual as decided by a free-running LFSR.
//
// state | meaning
// IDLE  | waiting for mut_start; mut_pop holds the last result
// RUN   | mutating individual idx, one per cycle
// DONE  | result ready; waits for mut_start to drop
module mutate_unit
    import mutate_unit_pkg::*;
#(
    parameter int          NUM_IND  = GA_NUM_IND,
    parameter int          IND_W    = GA_IND_W,
    parameter int          POP_W    = GA_POP_W,
    parameter logic [8:0]  MUT_RATE = GA_MUT_RATE,
    parameter logic [15:0] SEED     = GA_SEED
) (
    input  logic          clk,
    input  logic          rst_n,
    mutate_unit_if.slave  bus
);

    localparam int IDX_W = (NUM_IND > 1) ? $clog2(NUM_IND) : 1;
    localparam int PW    = $clog2(POP_W);

    mut_state_t       r_state;
    mut_state_t       w_state_nxt;
    logic [IDX_W-1:0] r_idx;
    logic [POP_W-1:0] r_pop;
    logic             r_done;

    logic             w_load;
    logic             w_run;
    logic             w_last;
    logic             w_hit;
    logic [15:0]      w_lfsr;
    logic [6:0]       w_off;
    logic [PW-1:0]    w_pos;
    logic             w_unused_lfsr_bit;

    ga_lfsr16 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (w_run),
        .seed  (SEED),
        .value (w_lfsr)
    );

    assign w_unused_lfsr_bit = w_lfsr[7];

    assign w_last = (r_idx == IDX_W'(NUM_IND - 1));
    assign w_hit  = ({1'b0, w_lfsr[15:8]} < MUT_RATE);

    // Offsets past the individual fold back by IND_W, which always lands in range since IND_W >= 65
    assign w_off = ({1'b0, w_lfsr[6:0]} < 8'(IND_W)) ? w_lfsr[6:0]
                                                     : 7'({1'b0, w_lfsr[6:0]} - 8'(IND_W));
    assign w_pos = PW'(r_idx) * PW'(IND_W) + PW'(w_off);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_run       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.mut_start) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_run = 1'b1;
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!bus.mut_start) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // mut_done trails the DONE state by one register stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx  <= '0;
            r_pop  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= (r_state == ST_DONE);
            if (w_load) begin
                r_pop <= bus.sel_pop;
                r_idx <= '0;
            end else if (w_run) begin
                r_pop[w_pos] <= r_pop[w_pos] ^ w_hit;
                if (!w_last) begin
                    r_idx <= r_idx + IDX_W'(1);
                end
            end
        end
    end

    assign bus.mut_pop  = r_pop;
    assign bus.mut_done = r_done;

endmodule

// File: tb/tb_mutate_unit.sv
// Three mutate units (rates 0, 256, 128) on shared stimulus, checked every cycle
// against a job-level model plus hand-derived LFSR expectations.
module tb_mutate_unit;

    localparam int NI = 75;
    localparam int IW = 100;
    localparam int PW = 7501;
    localparam int ND = 3;
    localparam logic [15:0] SEED = 16'hACE1;
    localparam logic [8:0] RATES [ND] = '{9'd0, 9'd256, 9'd128};

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [PW-1:0] sel;

    logic [PW-1:0] pop_o  [ND];
    logic          done_o [ND];

    int n_vec = 0;
    int n_err = 0;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        mutate_unit_if #(.POP_W(PW)) bus ();
        assign bus.mut_start = start;
        assign bus.sel_pop   = sel;
        assign pop_o[g]      = bus.mut_pop;
        assign done_o[g]     = bus.mut_done;
        mutate_unit #(
            .NUM_IND (NI),
            .IND_W   (IW),
            .POP_W   (PW),
            .MUT_RATE(RATES[g]),
            .SEED    (SEED)
        ) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );
    end

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [PW-1:0] run_job(input logic [PW-1:0] p, input logic [8:0] rate,
                                              input logic [15:0] lf_in, output logic [15:0] lf_out);
        logic [15:0] lf;
        int off;
        logic lsb;
        lf = lf_in;
        for (int i = 0; i < NI; i++) begin
            if (int'(lf[15:8]) < int'(rate)) begin
                off = int'(lf[6:0]);
                if (off >= IW) off = off - IW;
                p[i*IW + off] = ~p[i*IW + off];
            end
            lsb = lf[0];
            lf  = lf >> 1;
            if (lsb) lf = lf ^ 16'hB400;
        end
        lf_out = lf;
        return p;
    endfunction

    function automatic logic [PW-1:0] low_mask(input int n);
        logic [PW-1:0] one;
        one = 1;
        return (one << (n * IW)) - one;
    endfunction

    bit            m_act  [ND];
    int            m_t    [ND];
    logic [15:0]   m_lfsr [ND];
    logic [PW-1:0] m_base [ND];
    logic [PW-1:0] m_fin  [ND];
    logic [PW-1:0] e_pop  [ND];
    logic          e_done [ND];

    always @(posedge clk) begin
        logic [15:0] nl;
        logic [PW-1:0] x;
        #1;
        for (int g = 0; g < ND; g++) begin
            if (!rst_n) begin
                m_act[g]  = 0;
                m_t[g]    = 0;
                m_lfsr[g] = SEED;
                e_pop[g]  = '0;
                e_done[g] = 1'b0;
            end else if (m_act[g]) begin
                m_t[g]++;
                e_done[g] = (m_t[g] >= NI + 1);
                if (m_t[g] <= NI)
                    e_pop[g] = (m_fin[g] & low_mask(m_t[g])) | (m_base[g] & ~low_mask(m_t[g]));
                if (m_t[g] >= NI + 1 && !start) m_act[g] = 0;
            end else begin
                e_done[g] = 1'b0;
                if (start) begin
                    m_act[g]  = 1;
                    m_t[g]    = 0;
                    m_base[g] = sel;
                    m_fin[g]  = run_job(sel, RATES[g], m_lfsr[g], nl);
                    m_lfsr[g] = nl;
                    e_pop[g]  = sel;
                end
            end
            n_vec++;
            if (pop_o[g] !== e_pop[g]) begin
                n_err++;
                x = pop_o[g] ^ e_pop[g];
                $display("FAIL mut_pop dut%0d @%0t: %0d bits differ, actual[63:0]=%h required[63:0]=%h",
                         g, $time, $countones(x), pop_o[g][63:0], e_pop[g][63:0]);
            end
            n_vec++;
            if (done_o[g] !== e_done[g]) begin
                n_err++;
                $display("FAIL mut_done dut%0d @%0t: actual %b required %b", g, $time, done_o[g], e_done[g]);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] ind_diff(input logic [PW-1:0] a, input logic [PW-1:0] b, input int i);
        logic [PW-1:0] x;
        x = a ^ b;
        return 128'(x[i*IW +: IW]);
    endfunction

    function automatic logic [PW-1:0] rand_pop();
        logic [PW-1:0] p;
        for (int i = 0; i < PW; i++) p[i] = 1'($urandom_range(0, 1));
        return p;
    endfunction

    task automatic wait_done(output int k);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (done_o[1] !== 1'b1 && k < 300);
        if (k >= 300) begin
            n_vec++;
            n_err++;
            $display("FAIL done_timeout: actual mut_done %b after %0d cycles, required 1", done_o[1], k);
        end
    endtask

    // First job after reset: LFSR values ACE1, E270, 7138, 389C drive individuals 0..3
    task automatic check_seed_literals();
        int bad;
        logic [127:0] one;
        one = 1;
        chk("r256_ind0", ind_diff(pop_o[1], sel, 0), one << 97);
        chk("r256_ind1", ind_diff(pop_o[1], sel, 1), one << 12);
        chk("r256_ind2", ind_diff(pop_o[1], sel, 2), one << 56);
        chk("r256_ind3", ind_diff(pop_o[1], sel, 3), one << 28);
        chk("r128_ind0", ind_diff(pop_o[2], sel, 0), 0);
        chk("r128_ind1", ind_diff(pop_o[2], sel, 1), 0);
        chk("r128_ind2", ind_diff(pop_o[2], sel, 2), one << 56);
        chk("r128_ind3", ind_diff(pop_o[2], sel, 3), one << 28);
        chk("r0_unchanged", 128'($countones(pop_o[0] ^ sel)), 0);
        bad = 0;
        for (int i = 0; i < NI; i++)
            if ($countones(ind_diff(pop_o[1], sel, i)) != 1) bad++;
        chk("r256_one_flip_each", 128'(bad), 0);
        chk("r256_bit7500", 128'(pop_o[1][PW-1]), 128'(sel[PW-1]));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int k;
        int h;
        int guard;
        bit seen;
        logic [PW-1:0] snap;
        logic [PW-1:0] pop_a128;

        rst_n = 1'b0;
        start = 1'b0;
        sel   = '0;
        repeat (3) @(negedge clk);
        for (int g = 0; g < ND; g++) begin
            chk("reset_pop", 128'($countones(pop_o[g])), 0);
            chk("reset_done", 128'(done_o[g]), 0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // Job A: start held through DONE for 10 extra cycles
        sel   = rand_pop();
        start = 1'b1;
        wait_done(k);
        chk("latency_held", 128'(k - 1), 76);
        check_seed_literals();
        snap = pop_o[1];
        repeat (10) begin
            @(negedge clk);
            chk("done_hold", 128'(done_o[1]), 1);
            chk("pop_stable", 128'($countones(pop_o[1] ^ snap)), 0);
        end
        pop_a128 = pop_o[2];
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("done_drop", 128'(done_o[1]), 0);

        // Job B: same sel, 1-cycle start pulse; LFSR continues
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(k);
        chk("latency_pulse", 128'(k), 76);
        @(negedge clk);
        chk("done_pulse_width", 128'(done_o[1]), 0);
        chk("r128_jobs_differ", 128'(pop_o[2] != pop_a128), 1);
        @(negedge clk);

        // Job C: reset while idx 40 is being processed
        sel   = rand_pop();
        start = 1'b1;
        repeat (41) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        for (int g = 0; g < ND; g++) begin
            chk("async_rst_pop", 128'($countones(pop_o[g])), 0);
            chk("async_rst_done", 128'(done_o[g]), 0);
        end
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Job D: LFSR restarted from SEED
        sel   = rand_pop();
        start = 1'b1;
        wait_done(k);
        chk("latency_after_rst", 128'(k - 1), 76);
        check_seed_literals();
        start = 1'b0;
        repeat (3) @(negedge clk);

        // Random jobs with random start hold lengths
        repeat (4) begin
            sel   = rand_pop();
            h     = $urandom_range(1, 90);
            start = 1'b1;
            repeat (h) @(negedge clk);
            start = 1'b0;
            seen  = (done_o[1] === 1'b1);
            guard = 0;
            while (!(seen && done_o[1] === 1'b0) && guard < 300) begin
                @(negedge clk);
                guard++;
                if (done_o[1] === 1'b1) seen = 1;
            end
            if (guard >= 300) begin
                n_vec++;
                n_err++;
                $display("FAIL random_job_timeout: actual mut_done %b, required a completed pulse", done_o[1]);
            end
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual simulation still running, required completion");
        $fatal(1, "watchdog");
    end

endmodule
